score_tracker: RTL and testbench
================================

SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 win_left  input  1  level from playfield; high while left player holds a round win.
REQ-004 win_right  input  1  level from playfield; high while right player holds a round win.
REQ-005 clear  input  1  synchronous game restart, level-sensitive.
REQ-006 score_left  output  3  left score 0..7, unsigned, feeds the 7-seg decoder directly.
REQ-007 score_right  output  3  right score 0..7, unsigned, feeds the 7-seg decoder directly.
REQ-008 round_reset  output  1  one-cycle pulse telling the playfield to restart the round.
REQ-009 game_over  output  1  high while a player has reached 7.
REQ-010 winner  output  1  0 = left, 1 = right; valid only while game_over=1.

Function
REQ-011 Each win input SHALL be edge-detected against a registered previous sample: edge = sample AND NOT prev.
REQ-012 FSM states SHALL be PLAY, HOLD and OVER.
REQ-013 In PLAY, a left-only edge at clock edge N SHALL increment score_left at edge N, pulse round_reset for the following cycle, and move to HOLD. Right is symmetric.
REQ-014 In PLAY, simultaneous left and right edges SHALL leave both scores unchanged, pulse round_reset and move to HOLD (tie).
REQ-015 An increment that makes a score 7 SHALL move to OVER instead of HOLD, set game_over=1 and winner to that side, and still pulse round_reset.
REQ-016 Scores SHALL never wrap. 7 is terminal, and no increment SHALL occur outside PLAY.
REQ-017 HOLD SHALL return to PLAY on the first edge at which both sampled win inputs are low; edges seen in HOLD SHALL be ignored.
REQ-018 OVER SHALL freeze the scores, winner and game_over until clear.
REQ-019 clear=1 in any state SHALL, at that edge, zero both scores, game_over and winner, enter PLAY and pulse round_reset.
REQ-020 clear SHALL take priority over win edges in the same cycle.
REQ-021 round_reset SHALL be registered and high for exactly one cycle per event; back-to-back events SHALL give back-to-back pulses.

Reset
REQ-022 While reset_n=0: scores=0, game_over=0, winner=0, round_reset=0, state=PLAY, synchronizer flops=0.
REQ-023 Edge-detect prev registers SHALL reset to 1, so a win input held high through reset release scores nothing until it falls and rises again.
REQ-024 Reset asserted mid-round SHALL abandon any pending increment or pulse immediately.

Configuration
REQ-025 With macro SCORE_TRACKER_SYNC_EN defined, win_left, win_right and clear SHALL each pass through a 2-flop synchronizer before use, adding exactly 2 cycles latency. Example: a rising edge sampled at N increments at N+2.
REQ-026 Without SCORE_TRACKER_SYNC_EN, inputs SHALL be used directly with the latency of REQ-013. Function SHALL otherwise be identical.

Structure
REQ-027 Package score_pkg SHALL hold typedef score_t (3-bit unsigned), constant MAX_SCORE=7 and the FSM state enum.
REQ-028 One sub-module, edge_sync, SHALL be instantiated once per win input; it contains the optional synchronizer and the prev register and outputs the edge and the sampled level.
REQ-029 Expected implementation size is 120-400 lines total.

Verification
REQ-030 Left pulse high 3 cycles in PLAY -> score_left 0->1 exactly once, one round_reset pulse, HOLD until win_left falls, then PLAY.
REQ-031 Both wins rise in the same cycle -> scores stay 0/0, one round_reset pulse, state HOLD.
REQ-032 Seven right wins, each separated by release -> score_right=7, game_over=1, winner=1; an eighth win edge leaves all outputs unchanged.
REQ-033 In OVER, clear=1 for one cycle together with a win_left edge -> scores 0/0, game_over=0, one round_reset pulse, state PLAY, no increment.
REQ-034 win_left held high across reset release -> score_left stays 0; after win_left falls and rises -> score_left=1.
REQ-035 With SCORE_TRACKER_SYNC_EN: win_right rises before edge N -> score_right increments at N+2; without the macro -> at N.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker: score width, terminal score and FSM states.
package score_pkg;

    typedef logic [2:0] score_t;

    localparam score_t MAX_SCORE = 3'd7;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Saturating increment: a score at MAX_SCORE never wraps back to zero.
    function automatic score_t score_inc(input score_t s);
        return (s == MAX_SCORE) ? s : s + 3'd1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Per-input conditioning for one win line: optional 2-flop synchronizer (SCORE_TRACKER_SYNC_EN)
// followed by a rising-edge detector whose previous-sample register resets high.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic prev_d, prev_q;

`ifdef SCORE_TRACKER_SYNC_EN
    logic [1:0] sync_d, sync_q;
    logic [1:0] prime_d, prime_q;

    always_comb begin
        sync_d  = {sync_q[0], din};
        prime_d = {prime_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prime_q <= prime_d;
        end
    end

    assign level = sync_q[1];

    // Pin prev high until the synchronizer has flushed its reset zeros, so a line
    // held high through reset release is not seen as a fresh rise.
    always_comb prev_d = prime_q[1] ? level : 1'b1;
`else
    assign level = din;

    always_comb prev_d = level;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= 1'b1;
        else          prev_q <= prev_d;
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/score_tracker.sv
// Two-player score keeper: counts round wins to 7, pulses round_reset per event, freezes on game over.
// Define SCORE_TRACKER_SYNC_EN to pass win_left, win_right and clear through 2-flop synchronizers.
module score_tracker
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       win_left,
    input  logic       win_right,
    input  logic       clear,
    output logic [2:0] score_left,
    output logic [2:0] score_right,
    output logic       round_reset,
    output logic       game_over,
    output logic       winner
);

    logic   lvl_left, lvl_right, rise_left, rise_right, clr;

    state_e state_d, state_q;
    score_t score_left_d, score_left_q;
    score_t score_right_d, score_right_q;
    logic   round_reset_d, round_reset_q;
    logic   game_over_d, game_over_q;
    logic   winner_d, winner_q;

    edge_sync u_left (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (win_left),
        .level   (lvl_left),
        .rise    (rise_left)
    );

    edge_sync u_right (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (win_right),
        .level   (lvl_right),
        .rise    (rise_right)
    );

`ifdef SCORE_TRACKER_SYNC_EN
    logic [1:0] clr_sync_d, clr_sync_q;

    always_comb clr_sync_d = {clr_sync_q[0], clear};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) clr_sync_q <= '0;
        else          clr_sync_q <= clr_sync_d;
    end

    assign clr = clr_sync_q[1];
`else
    assign clr = clear;
`endif

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        game_over_d   = game_over_q;
        winner_d      = winner_q;
        round_reset_d = 1'b0;

        if (clr) begin
            state_d       = ST_PLAY;
            score_left_d  = '0;
            score_right_d = '0;
            game_over_d   = 1'b0;
            winner_d      = 1'b0;
            round_reset_d = 1'b1;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (rise_left && rise_right) begin
                        round_reset_d = 1'b1;
                        state_d       = ST_HOLD;
                    end else if (rise_left) begin
                        round_reset_d = 1'b1;
                        score_left_d  = score_inc(score_left_q);
                        if (score_left_d == MAX_SCORE) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                        end else begin
                            state_d     = ST_HOLD;
                        end
                    end else if (rise_right) begin
                        round_reset_d = 1'b1;
                        score_right_d = score_inc(score_right_q);
                        if (score_right_d == MAX_SCORE) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                        end else begin
                            state_d     = ST_HOLD;
                        end
                    end
                end
                // Wait for the playfield to drop both win levels before the next round counts.
                ST_HOLD: begin
                    if (!lvl_left && !lvl_right) state_d = ST_PLAY;
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_PLAY;
            score_left_q  <= '0;
            score_right_q <= '0;
            round_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            round_reset_q <= round_reset_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign round_reset = round_reset_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_score_tracker.sv
// Randomized bench for score_tracker against a cycle-level game model, plus directed scenarios.
module tb_score_tracker;

`ifdef SCORE_TRACKER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam int M_PLAY = 0;
    localparam int M_HOLD = 1;
    localparam int M_OVER = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       win_left = 1'b0;
    logic       win_right = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] score_left, score_right;
    logic       round_reset, game_over, winner;

    int n_chk = 0;
    int n_bad = 0;
    int rr_seen = 0;

    // game model state
    int m_sl, m_sr, mode, warm;
    bit m_go, m_win, m_rr, pl, pr;
    bit dl[2], dr[2], dc[2];

    logic r_wl = 1'b0, r_wr = 1'b0;
    int   s0;

    score_tracker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .win_left    (win_left),
        .win_right   (win_right),
        .clear       (clear),
        .score_left  (score_left),
        .score_right (score_right),
        .round_reset (round_reset),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sl = 0; m_sr = 0; mode = M_PLAY; warm = 0;
        m_go = 0; m_win = 0; m_rr = 0; pl = 1; pr = 1;
        for (int i = 0; i < 2; i++) begin
            dl[i] = 0; dr[i] = 0; dc[i] = 0;
        end
    endtask

    // One rising clock edge of the game rules, fed the raw pin values driven for that edge.
    task automatic model_edge(input bit wl, input bit wr, input bit cl);
        bit el, er, ec, up_l, up_r;
        if (LAT == 0) begin
            el = wl; er = wr; ec = cl;
        end else begin
            el = dl[0]; er = dr[0]; ec = dc[0];
            dl[0] = dl[1]; dl[1] = wl;
            dr[0] = dr[1]; dr[1] = wr;
            dc[0] = dc[1]; dc[1] = cl;
        end
        if (warm < LAT) begin
            warm++;
            up_l = 0; up_r = 0;
        end else begin
            up_l = el && !pl;
            up_r = er && !pr;
            pl = el; pr = er;
        end
        m_rr = 0;
        if (ec) begin
            m_sl = 0; m_sr = 0; m_go = 0; m_win = 0; mode = M_PLAY; m_rr = 1;
        end else if (mode == M_PLAY && (up_l || up_r)) begin
            m_rr = 1;
            if (up_l && up_r) mode = M_HOLD;
            else if (up_l) begin
                m_sl = m_sl + 1;
                if (m_sl == 7) begin mode = M_OVER; m_go = 1; m_win = 0; end
                else mode = M_HOLD;
            end else begin
                m_sr = m_sr + 1;
                if (m_sr == 7) begin mode = M_OVER; m_go = 1; m_win = 1; end
                else mode = M_HOLD;
            end
        end else if (mode == M_HOLD && !el && !er) begin
            mode = M_PLAY;
        end
    endtask

    task automatic step(input logic wl, input logic wr, input logic cl);
        @(negedge clk);
        win_left = wl; win_right = wr; clear = cl;
        @(posedge clk);
        model_edge(wl, wr, cl);
        #1;
        chk("score_left", score_left, m_sl);
        chk("score_right", score_right, m_sr);
        chk("round_reset", round_reset, m_rr);
        chk("game_over", game_over, m_go);
        chk("winner", winner, m_win);
        if (round_reset) rr_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic wl, input logic wr);
        @(negedge clk);
        win_left = wl; win_right = wr; clear = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_score_left", score_left, 0);
        chk("rst_score_right", score_right, 0);
        chk("rst_round_reset", round_reset, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset(1'b0, 1'b0);
        idle(3);

        // left held 3 cycles: one point, one pulse, back to play after release
        rr_seen = 0;
        repeat (3) step(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("hold3_score_left", score_left, 1);
        chk("hold3_pulses", rr_seen, 1);
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("play_again_left", score_left, 2);

        // tie
        step(1'b0, 1'b0, 1'b1);
        idle(LAT + 2);
        rr_seen = 0;
        repeat (2) step(1'b1, 1'b1, 1'b0);
        idle(4);
        chk("tie_left", score_left, 0);
        chk("tie_right", score_right, 0);
        chk("tie_pulses", rr_seen, 1);

        // right wins the game
        for (int k = 0; k < 7; k++) begin
            repeat (2) step(1'b0, 1'b1, 1'b0);
            idle(2);
        end
        idle(3);
        chk("win7_right", score_right, 7);
        chk("win7_over", game_over, 1);
        chk("win7_winner", winner, 1);
        rr_seen = 0;
        repeat (2) step(1'b0, 1'b1, 1'b0);
        idle(LAT + 3);
        chk("win8_right", score_right, 7);
        chk("win8_left", score_left, 0);
        chk("win8_over", game_over, 1);
        chk("win8_winner", winner, 1);
        chk("win8_pulses", rr_seen, 0);

        // clear beats a simultaneous left edge
        rr_seen = 0;
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        idle(LAT + 3);
        chk("clr_left", score_left, 0);
        chk("clr_right", score_right, 0);
        chk("clr_over", game_over, 0);
        chk("clr_pulses", rr_seen, 1);
        step(1'b1, 1'b0, 1'b0);
        idle(LAT + 3);
        chk("clr_then_play", score_left, 1);

        // win_left held through reset release
        step(1'b1, 1'b0, 1'b0);
        do_reset(1'b1, 1'b0);
        repeat (LAT + 3) step(1'b1, 1'b0, 1'b0);
        chk("held_rst_left", score_left, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(LAT + 3);
        chk("held_rst_rerise", score_left, 1);

        // input-to-score latency
        idle(3);
        s0 = m_sr;
        step(1'b0, 1'b1, 1'b0);
        chk("lat_n", score_right, (LAT == 0) ? s0 + 1 : s0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_n1", score_right, (LAT == 0) ? s0 + 1 : s0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_n2", score_right, s0 + 1);
        idle(4);

        // reset while a pulse is pending
        step(1'b1, 1'b0, 1'b0);
        do_reset(1'b0, 1'b0);
        idle(LAT + 2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(r_wl, r_wr);
            end else begin
                if ($urandom_range(0, 3) == 0) r_wl = ~r_wl;
                if ($urandom_range(0, 3) == 0) r_wr = ~r_wr;
                step(r_wl, r_wr, ($urandom_range(0, 99) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
